// File: rtl/prbs16_checker.sv
// prbs16_checker: PRBS x^16+x^14+x^13+x^11+1 receive checker with hunt/lock, flywheel and error counting
module prbs16_checker #(
  parameter int LOCK_N = 32,
  parameter int LOSS_N = 4
) (
  input  logic        CLK,
  input  logic        n_RESET,
  input  logic        DIN,
  input  logic        DIN_VALID,
  input  logic        CLR_ERR,
  output logic        LOCKED,
  output logic        ERR,
  output logic [15:0] ERR_COUNT,
  output logic        SYNC_LOSS
);
  typedef enum logic {HUNT, LOCK} state_t;
  localparam logic [7:0] lock_w = 8'(LOCK_N);
  localparam logic [3:0] loss_w = 4'(LOSS_N);
  state_t state, state_nx;
  logic [15:0] h, h_nx, cnt_nx;
  logic [4:0] fill, fill_nx, run, run_nx;
  logic [7:0] match, match_nx;
  logic [3:0] miss, miss_nx;
  logic err_nx, loss_nx, p, hit;
  assign p = h[10] ^ h[12] ^ h[13] ^ h[15];
  assign hit = DIN == p;
  assign LOCKED = state == LOCK;
  // next-state: hunt shifts in received bits, lock flywheels on the prediction
  always_comb begin
    state_nx = state;
    h_nx = h;
    fill_nx = fill;
    run_nx = run;
    match_nx = match;
    miss_nx = miss;
    err_nx = 1'b0;
    loss_nx = 1'b0;
    cnt_nx = ERR_COUNT;
    if (DIN_VALID) begin
      fill_nx = fill == 5'd16 ? fill : fill + 5'd1;
      if (state == HUNT) begin
        h_nx = {h[14:0], DIN};
        if (fill == 5'd16) begin
          match_nx = (hit && h != 16'd0) ? match + 8'd1 : 8'd0;
          if (match_nx == lock_w) begin
            state_nx = LOCK;
            match_nx = 8'd0;
            miss_nx = 4'd0;
            run_nx = 5'd0;
          end
        end
      end else begin
        h_nx = {h[14:0], p};
        if (hit) begin
          run_nx = run + 5'd1;
          if (run_nx == 5'd16) begin
            run_nx = 5'd0;
            miss_nx = 4'd0;
          end
        end else begin
          err_nx = 1'b1;
          run_nx = 5'd0;
          cnt_nx = &ERR_COUNT ? ERR_COUNT : ERR_COUNT + 16'd1;
          miss_nx = miss + 4'd1;
          if (miss_nx == loss_w) begin
            state_nx = HUNT;
            loss_nx = 1'b1;
            miss_nx = 4'd0;
            match_nx = 8'd0;
          end
        end
      end
    end
    if (CLR_ERR) cnt_nx = 16'd0;
  end
  // state and registered outputs
  always_ff @(posedge CLK or negedge n_RESET) begin
    if (!n_RESET) begin
      state <= HUNT;
      h <= 16'd0;
      fill <= 5'd0;
      run <= 5'd0;
      match <= 8'd0;
      miss <= 4'd0;
      ERR <= 1'b0;
      SYNC_LOSS <= 1'b0;
      ERR_COUNT <= 16'd0;
    end else begin
      state <= state_nx;
      h <= h_nx;
      fill <= fill_nx;
      run <= run_nx;
      match <= match_nx;
      miss <= miss_nx;
      ERR <= err_nx;
      SYNC_LOSS <= loss_nx;
      ERR_COUNT <= cnt_nx;
    end
  end
endmodule
